pcpi_dispatch: RTL and testbench
================================

Name: pcpi_dispatch

Overview:
- Sits between the core's PCPI port and the RV32M coprocessors (multiplier slave, divider slave).
- Registers each PCPI request, decodes it, and issues it to exactly one slave with registered operands.
- Holds the request until the slave responds, then returns the slave's write/result to the core as a single-cycle ready pulse.
- Provides a watchdog that aborts a slave that never answers.

Parameters:
- TIMEOUT_CYCLES, 64: cycles in BUSY without slave ready before abort; legal range 2..255.
- CNT_W, 8: width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- core_valid  in  1  core PCPI request valid
- core_insn  in  32  instruction word
- core_rs1  in  32  operand 1
- core_rs2  in  32  operand 2
- core_wr  out  1  result-write strobe, qualified by core_ready
- core_rd  out  32  result, qualified by core_ready
- core_wait  out  1  request claimed and in progress
- core_ready  out  1  one-cycle completion pulse
- sl_insn  out  32  registered instruction, broadcast to both slaves
- sl_rs1  out  32  registered operand 1, broadcast
- sl_rs2  out  32  registered operand 2, broadcast
- mul_valid  out  1  request to multiplier slave
- div_valid  out  1  request to divider slave
- mul_wr, mul_rd[31:0], mul_ready  in  multiplier response
- div_wr, div_rd[31:0], div_ready  in  divider response
- timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0; sl_* = 0; watchdog counter = 0.
- Decode: M-extension when insn[6:0]=0110011 and insn[31:25]=0000001.
  - insn[14]=0: target MUL (funct3 000..011).
  - insn[14]=1: target DIV (funct3 100..111).
  - Anything else: unclaimed.
- FSM states: IDLE, BUSY, RESP, IGNORE.
- IDLE:
  - On core_valid=1 with M-extension decode: latch insn/rs1/rs2 into sl_*, latch target, clear counter, go to BUSY.
  - On core_valid=1 with unclaimed decode: go to IGNORE. No wait, no ready; the core's own illegal-insn timeout handles it.
- BUSY:
  - Selected slave valid=1; other slave valid=0. core_wait=1. Counter increments each cycle.
  - Selected slave ready=1: capture its wr/rd into core_wr/core_rd, go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 with no ready: go to RESP with core_wr=0, core_rd=0; timeout_err=1 for that one cycle.
  - Ready and timeout in the same cycle: ready wins; no error pulse.
  - Ready from the non-selected slave: ignored.
- RESP:
  - core_ready=1 for exactly one cycle; slave valids=0; core_wait=0; next state IDLE.
  - core_rd reads 0 in every cycle where core_ready=0.
- IGNORE: stay while core_valid=1; return to IDLE when core_valid=0.
- Latency:
  - Request sampled at edge N → slave valid high from N+1.
  - Slave ready sampled at edge K → core_ready high in cycle K+1.
  - Minimum round trip: slave latency + 2.
- Slave valid drops in the cycle after slave ready. This satisfies slaves that gate acceptance on !ready.
- sl_* hold stable from entry into BUSY through RESP. Core operand changes after capture are ignored.
- Back-to-back: a new request is accepted in IDLE the cycle after RESP only if core_valid=1. No request is ever accepted in RESP.
- Reset asserted in BUSY: slave valid drops asynchronously; no core_ready is produced for the aborted request.

Optional Feature:
- Macro: PCPI_DISPATCH_STATS_EN.
- With the macro defined, adds outputs stat_mul[15:0], stat_div[15:0] and stat_tmo[15:0]:
  - stat_mul / stat_div increment on each completed MUL or DIV response (RESP entered via ready).
  - stat_tmo increments on each watchdog abort.
  - All three saturate at 16'hFFFF and clear on reset.
- Without the macro: ports and counters are absent; all other behaviour is identical.

Test Plan:
- DIVU: insn funct3=101, rs1=100, rs2=7; divider model answers wr=1, rd=14 after 34 cycles → div_valid high 34 cycles, mul_valid 0, then core_ready=1, core_wr=1, core_rd=14 one cycle later.
- MUL: rs1=6, rs2=7, mul model ready after 3 cycles with rd=42 → core_rd=42; round trip 5 cycles from core_valid sample to core_ready.
- Unclaimed: insn opcode 0010011 held 10 cycles → no slave valid, core_wait=0 and core_ready=0 throughout; FSM back in IDLE after core_valid drops.
- Timeout: DIV issued with div_ready tied 0, TIMEOUT_CYCLES=64 → core_ready=1, core_wr=0, timeout_err=1 in the same cycle, 65 cycles after issue; div_valid 0 afterwards.
- Reset mid-op: assert reset 5 cycles into a DIV → div_valid and core_wait fall with no clock edge; after release a new MUL completes normally.
- Back-to-back: MUL immediately followed by DIV (core_valid re-asserted the cycle after core_ready) → both complete with correct rd; sl_rs1 and sl_rs2 stable while each slave is valid.

Source files
------------

// File: rtl/pcpi_dispatch.sv
// ============================================================================
// pcpi_dispatch
//   Bridges the core's PCPI port to the RV32M coprocessors. Each M-extension
//   request is registered, decoded and issued to exactly one slave (multiplier
//   or divider) with registered operands. It is held until that slave answers.
//   The answer returns to the core as a single-cycle ready pulse. A watchdog
//   aborts a slave that never answers.
//
// Ports
//   clk, reset              clock (rising edge), asynchronous active-high reset
//   core_valid/insn/rs1/rs2 PCPI request from the core
//   core_wr/rd/ready        completion back to the core (wr/rd valid with ready)
//   core_wait               request claimed and in progress
//   sl_insn/rs1/rs2         registered request, broadcast to both slaves
//   mul_valid, div_valid    per-slave request strobes
//   mul_wr/rd/ready         multiplier response
//   div_wr/rd/ready         divider response
//   timeout_err             one-cycle pulse on watchdog abort
//
// Optional build macro
//   PCPI_DISPATCH_STATS_EN  adds saturating 16-bit counters stat_mul,
//                           stat_div and stat_tmo
// ============================================================================
module pcpi_dispatch #(
    parameter int TIMEOUT_CYCLES = 64,  // legal range 2..255
    parameter int CNT_W          = 8    // 2**CNT_W > TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_valid,
    input  logic [31:0] core_insn,
    input  logic [31:0] core_rs1,
    input  logic [31:0] core_rs2,
    output logic        core_wr,
    output logic [31:0] core_rd,
    output logic        core_wait,
    output logic        core_ready,
    output logic [31:0] sl_insn,
    output logic [31:0] sl_rs1,
    output logic [31:0] sl_rs2,
    output logic        mul_valid,
    output logic        div_valid,
    input  logic        mul_wr,
    input  logic [31:0] mul_rd,
    input  logic        mul_ready,
    input  logic        div_wr,
    input  logic [31:0] div_rd,
    input  logic        div_ready,
    output logic        timeout_err
`ifdef PCPI_DISPATCH_STATS_EN
    ,
    output logic [15:0] stat_mul,
    output logic [15:0] stat_div,
    output logic [15:0] stat_tmo
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP, S_IGNORE} state_t;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic              target_q;      // 0: multiplier, 1: divider
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       insn_q, rs1_q, rs2_q;
    logic              wr_q, tmo_q;
    logic [31:0]       rd_q;

    logic              is_m, sel_ready, sel_wr, tmo_hit;
    logic [31:0]       sel_rd;

    assign is_m      = (core_insn[6:0] == 7'b0110011) && (core_insn[31:25] == 7'b0000001);
    // Only the selected slave is listened to; the other's ready is ignored.
    assign sel_ready = target_q ? div_ready : mul_ready;
    assign sel_wr    = target_q ? div_wr    : mul_wr;
    assign sel_rd    = target_q ? div_rd    : mul_rd;
    assign tmo_hit   = (cnt_q == TMO_LAST);

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    // NOTE: state_d is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (core_valid) state_d = is_m ? S_BUSY : S_IGNORE;
            S_BUSY:   if (sel_ready || tmo_hit) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            S_IGNORE: if (!core_valid) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    // Result and error are gated by RESP so core_rd reads 0 whenever
    // core_ready is low, and reset removes every strobe asynchronously.
    always_comb begin
        mul_valid   = (state_q == S_BUSY) && !target_q;
        div_valid   = (state_q == S_BUSY) &&  target_q;
        core_wait   = (state_q == S_BUSY);
        core_ready  = (state_q == S_RESP);
        core_wr     = core_ready && wr_q;
        core_rd     = core_ready ? rd_q : 32'd0;
        timeout_err = core_ready && tmo_q;
        sl_insn     = insn_q;
        sl_rs1      = rs1_q;
        sl_rs2      = rs2_q;
    end

    // ---------------- datapath registers ----------------
    // NOTE: the operand/result registers are reset too: sl_* is visible to the
    // slaves and must read 0 out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_q <= 1'b0;
            cnt_q    <= '0;
            insn_q   <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            wr_q     <= 1'b0;
            rd_q     <= '0;
            tmo_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (core_valid && is_m) begin
                    insn_q   <= core_insn;
                    rs1_q    <= core_rs1;
                    rs2_q    <= core_rs2;
                    target_q <= core_insn[14];
                    cnt_q    <= '0;
                end
                S_BUSY: begin
                    cnt_q <= cnt_q + 1'b1;
                    // Ready beats a coincident timeout.
                    if (sel_ready) begin
                        wr_q  <= sel_wr;
                        rd_q  <= sel_rd;
                        tmo_q <= 1'b0;
                    end else if (tmo_hit) begin
                        wr_q  <= 1'b0;
                        rd_q  <= '0;
                        tmo_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PCPI_DISPATCH_STATS_EN
    logic [15:0] stat_mul_q, stat_div_q, stat_tmo_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_mul_q <= '0;
            stat_div_q <= '0;
            stat_tmo_q <= '0;
        end else if (state_q == S_BUSY) begin
            if (sel_ready) begin
                if (!target_q && stat_mul_q != 16'hFFFF) stat_mul_q <= stat_mul_q + 16'd1;
                if ( target_q && stat_div_q != 16'hFFFF) stat_div_q <= stat_div_q + 16'd1;
            end else if (tmo_hit && stat_tmo_q != 16'hFFFF) begin
                stat_tmo_q <= stat_tmo_q + 16'd1;
            end
        end
    end

    assign stat_mul = stat_mul_q;
    assign stat_div = stat_div_q;
    assign stat_tmo = stat_tmo_q;
`endif

endmodule

// File: tb/tb_pcpi_dispatch.sv
// Directed bench for pcpi_dispatch (default build, TIMEOUT_CYCLES = 64).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_pcpi_dispatch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        core_valid = 1'b0;
    logic [31:0] core_insn = '0, core_rs1 = '0, core_rs2 = '0;
    logic        core_wr, core_wait, core_ready;
    logic [31:0] core_rd, sl_insn, sl_rs1, sl_rs2;
    logic        mul_valid, div_valid, timeout_err;
    logic        mul_wr = 1'b0, mul_ready = 1'b0;
    logic [31:0] mul_rd = '0;
    logic        div_wr = 1'b0, div_ready = 1'b0;
    logic [31:0] div_rd = '0;

    int n_cmp = 0;
    int n_bad = 0;

    pcpi_dispatch #(.TIMEOUT_CYCLES(64), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .core_valid(core_valid), .core_insn(core_insn),
        .core_rs1(core_rs1), .core_rs2(core_rs2),
        .core_wr(core_wr), .core_rd(core_rd),
        .core_wait(core_wait), .core_ready(core_ready),
        .sl_insn(sl_insn), .sl_rs1(sl_rs1), .sl_rs2(sl_rs2),
        .mul_valid(mul_valid), .div_valid(div_valid),
        .mul_wr(mul_wr), .mul_rd(mul_rd), .mul_ready(mul_ready),
        .div_wr(div_wr), .div_rd(div_rd), .div_ready(div_ready),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] m_insn(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        core_valid = 1'b1;
        core_insn  = m_insn(f3);
        core_rs1   = a;
        core_rs2   = b;
        step();
        core_valid = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        #1;
        check("rst_ready", core_ready, 0);
        check("rst_wait", core_wait, 0);
        check("rst_mul_valid", mul_valid, 0);
        check("rst_div_valid", div_valid, 0);
        check("rst_sl_insn", sl_insn, 0);
        check("rst_sl_rs1", sl_rs1, 0);
        check("rst_core_rd", core_rd, 0);
        check("rst_tmo", timeout_err, 0);
        step();
        reset = 1'b0;
        step();

        // ---------------- DIVU 100/7 after 34 cycles ----------------
        issue(3'b101, 32'd100, 32'd7);
        core_rs1 = 32'd555;                      // post-capture changes ignored
        core_rs2 = 32'd666;
        for (int i = 1; i <= 34; i++) begin
            check("divu_div_valid", div_valid, 1);
            check("divu_mul_valid", mul_valid, 0);
            check("divu_wait", core_wait, 1);
            check("divu_ready_low", core_ready, 0);
            check("divu_sl_rs1", sl_rs1, 100);
            check("divu_sl_rs2", sl_rs2, 7);
            check("divu_sl_insn", sl_insn, m_insn(3'b101));
            mul_ready = (i == 5);                // non-selected slave: ignored
            mul_rd    = 32'hDEAD;
            if (i == 34) begin
                div_ready = 1'b1; div_wr = 1'b1; div_rd = 32'd14;
            end
            step();
        end
        div_ready = 1'b0;
        check("divu_core_ready", core_ready, 1);
        check("divu_core_wr", core_wr, 1);
        check("divu_core_rd", core_rd, 14);
        check("divu_div_valid_drop", div_valid, 0);
        check("divu_wait_drop", core_wait, 0);
        check("divu_tmo", timeout_err, 0);
        step();
        check("divu_ready_pulse", core_ready, 0);
        check("divu_rd_zero_after", core_rd, 0);

        // ---------------- MUL 6*7 after 3 cycles ----------------
        issue(3'b000, 32'd6, 32'd7);
        for (int i = 1; i <= 3; i++) begin
            check("mul_mul_valid", mul_valid, 1);
            check("mul_div_valid", div_valid, 0);
            check("mul_ready_low", core_ready, 0);
            if (i == 3) begin
                mul_ready = 1'b1; mul_wr = 1'b1; mul_rd = 32'd42;
            end
            step();
        end
        mul_ready = 1'b0;
        check("mul_core_ready", core_ready, 1);
        check("mul_core_rd", core_rd, 42);
        check("mul_core_wr", core_wr, 1);
        check("mul_valid_drop", mul_valid, 0);
        step();
        check("mul_rd_gated", core_rd, 0);       // mul_rd still 42 on the input
        check("mul_wr_gated", core_wr, 0);

        // ---------------- unclaimed opcode held 10 cycles ----------------
        core_valid = 1'b1;
        core_insn  = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0010011};
        for (int i = 0; i < 10; i++) begin
            step();
            check("ign_mul_valid", mul_valid, 0);
            check("ign_div_valid", div_valid, 0);
            check("ign_wait", core_wait, 0);
            check("ign_ready", core_ready, 0);
        end
        core_valid = 1'b0;
        step();                                  // back to IDLE

        // ---------------- back-to-back MUL then DIV ----------------
        issue(3'b000, 32'd3, 32'd5);
        check("b2b_mul_valid", mul_valid, 1);
        check("b2b_mul_sl_rs1", sl_rs1, 3);
        check("b2b_mul_sl_rs2", sl_rs2, 5);
        mul_ready = 1'b1; mul_wr = 1'b1; mul_rd = 32'd15;
        core_rs1 = 32'd99;
        step();
        mul_ready = 1'b0;
        check("b2b_mul_ready", core_ready, 1);
        check("b2b_mul_rd", core_rd, 15);
        check("b2b_sl_rs1_hold", sl_rs1, 3);
        // Present the DIV already during RESP: it must not be taken there.
        core_valid = 1'b1;
        core_insn  = m_insn(3'b101);
        core_rs1   = 32'd20;
        core_rs2   = 32'd4;
        step();
        check("b2b_no_accept_in_resp", div_valid, 0);
        check("b2b_idle_wait", core_wait, 0);
        step();
        core_valid = 1'b0;
        core_rs1   = 32'd1234;
        check("b2b_div_valid", div_valid, 1);
        check("b2b_div_sl_rs1", sl_rs1, 20);
        check("b2b_div_sl_rs2", sl_rs2, 4);
        step();
        check("b2b_div_sl_rs1_hold", sl_rs1, 20);
        div_ready = 1'b1; div_wr = 1'b1; div_rd = 32'd5;
        step();
        div_ready = 1'b0;
        check("b2b_div_ready", core_ready, 1);
        check("b2b_div_rd", core_rd, 5);
        step();

        // ---------------- watchdog timeout ----------------
        div_wr = 1'b1; div_rd = 32'd777;         // must not leak on abort
        issue(3'b100, 32'd9, 32'd3);
        for (int i = 1; i <= 64; i++) begin
            check("tmo_div_valid", div_valid, 1);
            check("tmo_ready_low", core_ready, 0);
            check("tmo_err_low", timeout_err, 0);
            step();
        end
        check("tmo_core_ready", core_ready, 1);
        check("tmo_core_wr", core_wr, 0);
        check("tmo_core_rd", core_rd, 0);
        check("tmo_err", timeout_err, 1);
        check("tmo_div_valid_drop", div_valid, 0);
        step();
        check("tmo_err_pulse", timeout_err, 0);
        check("tmo_div_valid_after", div_valid, 0);

        // ---------------- ready coincident with timeout ----------------
        issue(3'b100, 32'd9, 32'd3);
        repeat (63) step();
        check("race_still_busy", div_valid, 1);
        div_ready = 1'b1; div_wr = 1'b1; div_rd = 32'd3;
        step();
        div_ready = 1'b0;
        check("race_ready", core_ready, 1);
        check("race_wr", core_wr, 1);
        check("race_rd", core_rd, 3);
        check("race_no_err", timeout_err, 0);
        step();

        // ---------------- reset in the middle of a DIV ----------------
        div_wr = 1'b0; div_rd = '0;
        issue(3'b101, 32'd50, 32'd5);
        repeat (5) step();
        check("rmid_busy", div_valid, 1);
        reset = 1'b1;
        #1;                                      // no clock edge in between
        check("rmid_div_valid_async", div_valid, 0);
        check("rmid_wait_async", core_wait, 0);
        step();
        check("rmid_no_ready", core_ready, 0);
        reset = 1'b0;
        step();
        check("rmid_idle_ready", core_ready, 0);
        issue(3'b000, 32'd8, 32'd9);
        check("rmid_mul_valid", mul_valid, 1);
        mul_ready = 1'b1; mul_wr = 1'b1; mul_rd = 32'd72;
        step();
        mul_ready = 1'b0;
        check("rmid_mul_ready", core_ready, 1);
        check("rmid_mul_rd", core_rd, 72);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
